// File: rtl/rank_filter_1d.sv
`default_nettype none
// ============================================================================
// rank_filter_1d : sliding-window rank-order filter (min/median/max), 4-cycle latency
// Revision: 1.0
// ============================================================================
module rank_filter_1d #(
  parameter int DW  = 8,
  parameter int KSZ = 5,
  parameter int RW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          line_start,
  input  logic [RW-1:0] rank_sel,
  output logic [DW-1:0] dout,
  output logic          dout_valid
);

  localparam logic [RW-1:0] c_ksz      = RW'(KSZ);
  localparam logic [RW-1:0] c_rank_max = RW'(KSZ - 1);

  logic [KSZ-1:0][DW-1:0]  w_q, w_d;
  logic [RW-1:0]           cnt_q, cnt_d;
  logic                    tok0_q, tok0_d;
  logic [RW-1:0]           rs0_q, rs0_d;
  logic [KSZ-1:0][KSZ-1:0] cmp_q, cmp_d;
  logic [KSZ-1:0][DW-1:0]  win1_q, win1_d;
  logic                    tok1_q, tok1_d;
  logic [RW-1:0]           rs1_q, rs1_d;
  logic [KSZ-1:0][RW-1:0]  rank_q, rank_d;
  logic [KSZ-1:0][DW-1:0]  win2_q, win2_d;
  logic                    tok2_q, tok2_d;
  logic [RW-1:0]           rs2_q, rs2_d;
  logic [DW-1:0]           dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    complete;

  always_comb begin
    w_d      = w_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (din_valid) begin
      for (int i = KSZ - 1; i > 0; i--) begin
        w_d[i] = w_q[i-1];
      end
      w_d[0] = din;
      // Stale entries from the previous line stay in w but are masked by the count.
      if (line_start) begin
        cnt_d = RW'(1);
      end else if (cnt_q != c_ksz) begin
        cnt_d = cnt_q + RW'(1);
      end
      complete = (cnt_d == c_ksz);
    end
    tok0_d = complete;
    rs0_d  = (rank_sel > c_rank_max) ? c_rank_max : rank_sel;

    // Position tie-break makes every element's rank unique.
    for (int i = 0; i < KSZ; i++) begin
      for (int j = 0; j < KSZ; j++) begin
        cmp_d[i][j] = (w_q[j] < w_q[i]) || ((j < i) && (w_q[j] == w_q[i]));
      end
    end
    win1_d = w_q;
    tok1_d = tok0_q;
    rs1_d  = rs0_q;

    for (int i = 0; i < KSZ; i++) begin
      rank_d[i] = '0;
      for (int j = 0; j < KSZ; j++) begin
        rank_d[i] = rank_d[i] + RW'(cmp_q[i][j]);
      end
    end
    win2_d = win1_q;
    tok2_d = tok1_q;
    rs2_d  = rs1_q;

    dout_d = dout_q;
    if (tok2_q) begin
      for (int i = 0; i < KSZ; i++) begin
        if (rank_q[i] == rs2_q) begin
          dout_d = win2_q[i];
        end
      end
    end
    dout_valid_d = tok2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q          <= '0;
      cnt_q        <= '0;
      tok0_q       <= 1'b0;
      rs0_q        <= '0;
      cmp_q        <= '0;
      win1_q       <= '0;
      tok1_q       <= 1'b0;
      rs1_q        <= '0;
      rank_q       <= '0;
      win2_q       <= '0;
      tok2_q       <= 1'b0;
      rs2_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      w_q          <= w_d;
      cnt_q        <= cnt_d;
      tok0_q       <= tok0_d;
      rs0_q        <= rs0_d;
      cmp_q        <= cmp_d;
      win1_q       <= win1_d;
      tok1_q       <= tok1_d;
      rs1_q        <= rs1_d;
      rank_q       <= rank_d;
      win2_q       <= win2_d;
      tok2_q       <= tok2_d;
      rs2_q        <= rs2_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rank_filter_1d.sv
`default_nettype none
// ============================================================================
// tb_rank_filter_1d : directed-vector scoreboard bench for rank_filter_1d
// Revision: 1.0
// ============================================================================
module tb_rank_filter_1d;
  localparam int DW  = 8;
  localparam int KSZ = 5;
  localparam int RW  = 4;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic [DW-1:0] din        = '0;
  logic          din_valid  = 1'b0;
  logic          line_start = 1'b0;
  logic [RW-1:0] rank_sel   = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;

  rank_filter_1d #(.DW(DW), .KSZ(KSZ), .RW(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .line_start (line_start),
    .rank_sel   (rank_sel),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  int   cyc    = 0;
  logic rst_d1 = 1'b0;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_d1 <= rst;
  end

  typedef struct {
    int            at;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e_m;
  int            n_cmp    = 0;
  int            n_fail   = 0;
  logic [DW-1:0] hold_ref = '0;

  // Monitor: pops one expectation per dout_valid strobe, otherwise checks hold.
  always @(negedge clk) begin
    if (rst_d1) begin
      n_cmp++;
      hold_ref = '0;
      if (dout !== '0 || dout_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state cycle %0d: dout=%0d dout_valid=%b, required dout=0 dout_valid=0",
                 cyc, dout, dout_valid);
      end
    end else if (dout_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_out cycle %0d: dout_valid=1 dout=%0d, required no output", cyc, dout);
      end else begin
        e_m      = exp_q.pop_front();
        hold_ref = e_m.val;
        if (cyc != e_m.at || dout !== e_m.val) begin
          n_fail++;
          $display("FAIL result: got dout=%0d at cycle %0d, required dout=%0d at cycle %0d",
                   dout, cyc, e_m.val, e_m.at);
        end
      end
    end else begin
      n_cmp++;
      if (dout_valid !== 1'b0 || dout !== hold_ref) begin
        n_fail++;
        $display("FAIL hold cycle %0d: dout=%0d dout_valid=%b, required dout=%0d dout_valid=0",
                 cyc, dout, dout_valid, hold_ref);
      end
    end
  end

  task automatic drive(input logic v, input logic ls, input logic [DW-1:0] d,
                       input logic [RW-1:0] rs, input logic ex, input logic [DW-1:0] ev);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    din_valid  = v;
    line_start = ls;
    din        = d;
    rank_sel   = rs;
    if (ex) exp_q.push_back('{at: cyc + 4, val: ev});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'hAA, 4'd0, 1'b0, 8'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // Basic median, then one more sample after fill
    drive(1, 1, 8'd10, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd50, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd30, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd20, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd40, 4'd2, 1, 8'd30);
    drive(1, 0, 8'd60, 4'd2, 1, 8'd40);
    idle(6);

    // Min, max, clamp; rank_sel only counts on the completing sample
    drive(1, 1, 8'd10, 4'd4, 0, 8'd0);
    drive(1, 0, 8'd50, 4'd4, 0, 8'd0);
    drive(1, 0, 8'd30, 4'd4, 0, 8'd0);
    drive(1, 0, 8'd20, 4'd4, 0, 8'd0);
    drive(1, 0, 8'd40, 4'd0, 1, 8'd10);
    drive(1, 1, 8'd10, 4'd0, 0, 8'd0);
    drive(1, 0, 8'd50, 4'd0, 0, 8'd0);
    drive(1, 0, 8'd30, 4'd0, 0, 8'd0);
    drive(1, 0, 8'd20, 4'd0, 0, 8'd0);
    drive(1, 0, 8'd40, 4'd4, 1, 8'd50);
    drive(1, 1, 8'd10, 4'd0, 0, 8'd0);
    drive(1, 0, 8'd50, 4'd0, 0, 8'd0);
    drive(1, 0, 8'd30, 4'd0, 0, 8'd0);
    drive(1, 0, 8'd20, 4'd0, 0, 8'd0);
    drive(1, 0, 8'd40, 4'd7, 1, 8'd50);

    // Ties: window {7,7,7,3,3} at ranks 2, 1, 4
    drive(1, 1, 8'd7, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd7, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd7, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd3, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd3, 4'd2, 1, 8'd7);
    drive(1, 1, 8'd7, 4'd1, 0, 8'd0);
    drive(1, 0, 8'd7, 4'd1, 0, 8'd0);
    drive(1, 0, 8'd7, 4'd1, 0, 8'd0);
    drive(1, 0, 8'd3, 4'd1, 0, 8'd0);
    drive(1, 0, 8'd3, 4'd1, 1, 8'd3);
    drive(1, 1, 8'd7, 4'd4, 0, 8'd0);
    drive(1, 0, 8'd7, 4'd4, 0, 8'd0);
    drive(1, 0, 8'd7, 4'd4, 0, 8'd0);
    drive(1, 0, 8'd3, 4'd4, 0, 8'd0);
    drive(1, 0, 8'd3, 4'd4, 1, 8'd7);

    // Line restart in the middle of a partial window
    drive(1, 1, 8'd1, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd2, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd3, 4'd2, 0, 8'd0);
    drive(1, 1, 8'd9, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd1, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd5, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd2, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd8, 4'd2, 1, 8'd5);
    idle(6);

    // Gapped stream 1..20, median; gaps carry junk and an unqualified line_start
    for (int k = 1; k <= 20; k++) begin
      drive(1, k == 1, 8'(k), 4'd2, k >= 5, 8'(k - 2));
      repeat ((k % 3 == 0) ? 2 : 1) drive(0, k[0], 8'hEE, 4'd0, 0, 8'd0);
    end
    idle(6);

    // Reset with three results in flight, same cycle as a valid line_start sample
    for (int k = 1; k <= 7; k++) begin
      drive(1, k == 1, 8'(k), 4'd2, 0, 8'd0);
    end
    @(posedge clk);
    #1;
    rst        = 1'b1;
    din_valid  = 1'b1;
    line_start = 1'b1;
    din        = 8'd99;
    rank_sel   = 4'd2;
    drive(1, 0, 8'd5, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd4, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd3, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd2, 4'd2, 0, 8'd0);
    drive(1, 0, 8'd1, 4'd2, 1, 8'd3);
    idle(8);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_outputs: %0d expected results never appeared, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rank_filter_1d.md
Name: rank_filter_1d

Overview:
Parametrised 1-D rank-order filter for streaming pixel data. It keeps a sliding window of the last KSZ valid samples and outputs the sample at a runtime-selectable rank: 0 = min, KSZ>>1 = median, KSZ-1 = max. It adds per-line window restart and a fixed pipelined latency, and is the building block for separable rank and morphological filters in the nonlinear-filter chain.

Parameters:
DW, 8, sample width in bits.
KSZ, 5, window length; odd, 3..15.
RW, 4, rank/count width; must satisfy 2^RW >= KSZ.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
din  in  DW  input sample, unsigned.
din_valid  in  1  din is accepted this cycle; no backpressure.
line_start  in  1  qualified by din_valid; this sample is the first of a new line.
rank_sel  in  RW  requested rank; sampled with the window-completing sample.
dout  out  DW  selected sample.
dout_valid  out  1  single-cycle strobe per completed window.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high. No asynchronous reset anywhere.
- Window: shift register w[0..KSZ-1], where w[0] is the newest sample.
  - Shifts only when din_valid=1.
  - On line_start&din_valid, w[0]<=din and the fill counter <=1. Older entries still shift, but they are excluded by the counter.
- Fill counter: saturating count 0..KSZ, incremented on each din_valid.
  - A window is "complete" in any cycle where din_valid=1 and the post-update count is KSZ.
  - Each valid sample after fill therefore completes a window.
  - line_start with KSZ=3 needs 3 samples before the next output.
- Rank definition (ties broken by position, so ranks form a permutation of 0..KSZ-1):
  - rank_i = #{j : w[j] < w[i]} + #{j < i : w[j] == w[i]}.
- Pipeline: the pipeline is free-running (not stalled by din_valid gaps). A valid token and the rank_sel snapshot travel with each window.
  - S0 (edge ending cycle N): window update; token <= complete; rs0 <= min(rank_sel, KSZ-1).
  - S1: register the KSZ x KSZ compare matrix and copy of the window.
  - S2: register the per-element rank sums, each RW bits wide; no overflow is possible.
  - S3: register dout <= the window copy whose rank == rs; exactly one match is guaranteed. Register dout_valid <= token.
- Latency: if din_valid completes a window in cycle N, dout_valid=1 in cycle N+4. Throughput is one result per clock.
- dout_valid is high for exactly one cycle per complete window. dout holds its last value while dout_valid=0.
- rank_sel >= KSZ is clamped to KSZ-1 (max). Changing rank_sel between windows affects only windows completed after the change.
- Reset values: window=0, count=0, all tokens=0, dout=0, dout_valid=0.
  - Reset mid-operation discards all in-flight results; no dout_valid until KSZ new samples arrive.
  - rst has priority over din_valid/line_start in the same cycle.
- line_start without din_valid is ignored.
- din_valid gaps do not disturb window contents or results in flight.

Test Plan:
1. KSZ=5, rank_sel=2, din 10,50,30,20,40 on consecutive cycles, then 60 -> dout_valid only in cycles 5th+4 and 6th+4; dout=30 then 40.
2. Same first window with rank_sel=0, then a repeat with rank_sel=4 -> dout=10 and dout=50. rank_sel=7 -> 50 (clamp).
3. Ties: din 7,7,7,3,3 -> rank 2 gives 7, rank 1 gives 3, rank 4 gives 7. Exactly one dout_valid per window, with no X or missed output.
4. Send 3 samples, then line_start with 9, then 1,5,2,8 -> no dout_valid until the 5th sample of the new line. Median of {9,1,5,2,8} = 5.
5. din_valid asserted every other cycle (and in random gaps) with stream 1..20, median -> outputs 3,4,...,18. Each appears exactly 4 cycles after its completing sample.
6. rst pulsed for one cycle while 3 results are in flight -> those 3 are dropped; dout=0, dout_valid=0. The next output comes only after 5 fresh samples.
